nfa_stream_feeder: RTL and testbench
====================================

# nfa_stream_feeder

Byte-stream front end that drives the generated NFA engine array. It accepts packet bytes on a valid/ready stream and produces the per-packet `sod` clear pulse, the per-byte `en` strobe and the character bus for the character-class decoder. After the last byte it flushes the engine pipeline, samples the sticky engine `out` flags and returns one match report per packet on a valid/ready result port. One instance sits between the packet buffer and the bank of `engine_N` blocks plus their shared decoder.

## Interface
- `NUM_ENG`, 8, number of engine match lines sampled.
- `LEN_W`, 16, width of the packet length counter.
- `DRAIN_CYC`, 2, killed-character cycles between the last byte and the match sample. Minimum 1.
- `clk` input 1, sole clock, rising edge.
- `rst` input 1, asynchronous, active-low reset.
- `s_valid` input 1, upstream byte valid.
- `s_ready` output 1, byte accepted when `s_valid & s_ready`.
- `s_data` input 8, packet byte.
- `s_last` input 1, marks the final byte of the packet.
- `char_o` output 8, registered byte to the decoder.
- `chr_kill` output 1, decoder forces every class line low while this is high.
- `en` output 1, engine clock enable.
- `sod` output 1, engine synchronous clear.
- `match_i` input NUM_ENG, sticky engine `out` lines.
- `r_valid` output 1, report valid.
- `r_ready` input 1, report consumed.
- `r_match` output NUM_ENG, sampled match vector.
- `r_len` output LEN_W, bytes in the packet, saturating.
- `r_ovf` output 1, set when the length saturated.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- IDLE:
  - `s_ready`=0.
  - `s_valid`=1 moves to CLEAR. The byte is not consumed.
- CLEAR lasts exactly 1 cycle:
  - Outputs: `sod`=1, `en`=1, `chr_kill`=1.
  - Clears the length counter and `r_ovf`.
  - Moves to STREAM.
- STREAM:
  - `s_ready`=1.
  - Each accepted byte loads `char_o`, pulses `en` for 1 cycle with `chr_kill`=0, and increments `r_len`.
  - `r_len` saturates at 2^LEN_W−1. The first increment attempted at saturation sets `r_ovf`.
  - An accepted byte with `s_last`=1 moves to DRAIN. `s_ready` drops in the next cycle.
  - Idle cycles (no acceptance) give `en`=0.
- DRAIN lasts DRAIN_CYC cycles:
  - Outputs: `en`=1, `chr_kill`=1, `char_o`=0x00.
  - This pushes the final state bits into the sticky output stage without any class line matching.
  - On the final drain cycle, `match_i` is registered into `r_match` and the FSM moves to REPORT.
- REPORT:
  - `r_valid`=1. `r_match`, `r_len` and `r_ovf` stay stable.
  - The cycle where `r_valid & r_ready` returns the FSM to IDLE. The next packet's CLEAR follows no earlier than the cycle after that.
  - `s_ready`=0 throughout.
- Zero-length packets cannot occur, because `s_last` is carried on a byte.

## Timing
- Reset values: state IDLE; `s_ready`, `en`, `sod`, `chr_kill`, `r_valid`, `r_ovf` = 0; `char_o`, `r_len`, `r_match` = 0.
- Reset asserted mid-packet aborts the packet. No report is produced and the next packet starts with a CLEAR.
- Byte accepted at edge k: `char_o`/`en` valid in cycle k→k+1, and the engine state updates at edge k+1.
- Last byte accepted at edge k gives DRAIN cycles k+1 … k+DRAIN_CYC. `r_valid` rises at edge k+DRAIN_CYC+1.
- Throughput is 1 byte/cycle in STREAM. Per-packet overhead is 1 (CLEAR) + DRAIN_CYC + 1 (minimum REPORT) cycles, plus 1 IDLE cycle.
- `r_valid` must not drop without `r_ready`, and the report fields must not change while `r_valid` is high.
- All outputs are registered. There is no combinational path from `s_valid` to `s_ready` or from `r_ready` to `r_valid`.

## Structure
- Shared package `nfa_pkg`:
  - FSM state enum `feed_state_t`.
  - Constant `CHR_NUL`=8'h00.
  - Default `LEN_W`.
- Single module, no sub-modules. The length counter and drain counter are in-line.

## Test plan
- Feed "/cbn/c.smx?u=" (13 bytes, `s_last` on '=') with a behavioural engine_4 model on `match_i[4]`. Required: `r_match`=0x10, `r_len`=13, `r_ovf`=0.
- Feed "/cbn/b.smx" followed by "\r", "u=". Required: `r_match`=0, `r_len`=13.
- Hold `r_ready`=0 for 20 cycles while `s_valid`=1. Required: `r_valid` and the report fields are stable, and `s_ready`=0 throughout. After the handshake, the next packet begins with a 1-cycle `sod`.
- Use LEN_W=4 and a 20-byte packet. Required: `r_len`=15, `r_ovf`=1.
- Use a back-to-back 1-byte packet with DRAIN_CYC=2. Required: `sod` at cycle 1, `en` pulses at cycles 2, 3 and 4, and `r_valid` at cycle 5.
- Assert `rst` low during STREAM byte 5. Required: all outputs return to 0 asynchronously, no report is produced, and a later packet reports its correct length.

Source files
------------

// File: rtl/nfa_pkg.sv
// Shared types and constants for the NFA stream front end.
package nfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } feed_state_t;

  localparam logic [7:0] CHR_NUL   = 8'h00;
  localparam int         DEF_LEN_W = 16;

endpackage

// File: rtl/nfa_stream_feeder_if.sv
// Byte stream, engine drive and match report bundle for nfa_stream_feeder.
interface nfa_stream_feeder_if #(
  parameter int NUM_ENG = 8,
  parameter int LEN_W   = nfa_pkg::DEF_LEN_W
);
  logic               s_valid;
  logic               s_ready;
  logic [7:0]         s_data;
  logic               s_last;
  logic [7:0]         char_o;
  logic               chr_kill;
  logic               en;
  logic               sod;
  logic [NUM_ENG-1:0] match_i;
  logic               r_valid;
  logic               r_ready;
  logic [NUM_ENG-1:0] r_match;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovf;

  // Environment side: packet buffer, engine array and report consumer.
  modport master (
    output s_valid, s_data, s_last, match_i, r_ready,
    input  s_ready, char_o, chr_kill, en, sod, r_valid, r_match, r_len, r_ovf
  );

  modport slave (
    input  s_valid, s_data, s_last, match_i, r_ready,
    output s_ready, char_o, chr_kill, en, sod, r_valid, r_match, r_len, r_ovf
  );
endinterface

// File: rtl/nfa_stream_feeder.sv
// Feeds packet bytes into the NFA engine array, flushes it after the last
// byte and returns one registered match report per packet.
module nfa_stream_feeder
  import nfa_pkg::*;
#(
  parameter int NUM_ENG   = 8,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int DRAIN_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  nfa_stream_feeder_if.slave bus
);

  localparam int               CNT_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  feed_state_t        state_q, state_d;
  logic               s_ready_q, s_ready_d;
  logic               en_q, en_d;
  logic               sod_q, sod_d;
  logic               kill_q, kill_d;
  logic [7:0]         char_q, char_d;
  logic               r_valid_q, r_valid_d;
  logic [NUM_ENG-1:0] r_match_q, r_match_d;
  logic [LEN_W-1:0]   r_len_q, r_len_d;
  logic               r_ovf_q, r_ovf_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               accept;

  assign accept = s_ready_q & bus.s_valid;

  // Every output is a register loaded with the value for the coming cycle, so
  // s_ready is already high during CLEAR and the first byte lands right after it.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    en_d        = 1'b0;
    sod_d       = 1'b0;
    kill_d      = 1'b0;
    char_d      = char_q;
    r_valid_d   = r_valid_q;
    r_match_d   = r_match_q;
    r_len_d     = r_len_q;
    r_ovf_d     = r_ovf_q;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          state_d   = ST_CLEAR;
          s_ready_d = 1'b1;
          sod_d     = 1'b1;
          en_d      = 1'b1;
          kill_d    = 1'b1;
          char_d    = CHR_NUL;
          r_len_d   = '0;
          r_ovf_d   = 1'b0;
        end
      end
      ST_CLEAR, ST_STREAM: begin
        state_d = ST_STREAM;
        if (accept) begin
          en_d   = 1'b1;
          char_d = bus.s_data;
          if (r_len_q == LEN_MAX) r_ovf_d = 1'b1;
          else                    r_len_d = r_len_q + LEN_W'(1);
          if (bus.s_last) begin
            state_d     = ST_DRAIN;
            s_ready_d   = 1'b0;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        // Killed characters push the last state bits into the sticky outputs.
        if (drain_cnt_q == CNT_W'(DRAIN_CYC)) begin
          state_d   = ST_REPORT;
          r_valid_d = 1'b1;
          r_match_d = bus.match_i;
        end else begin
          en_d        = 1'b1;
          kill_d      = 1'b1;
          char_d      = CHR_NUL;
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        if (bus.r_ready) begin
          state_d   = ST_IDLE;
          r_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  // NOTE: every register, including the report fields, is reset so an aborted packet leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      en_q        <= 1'b0;
      sod_q       <= 1'b0;
      kill_q      <= 1'b0;
      char_q      <= CHR_NUL;
      r_valid_q   <= 1'b0;
      r_match_q   <= '0;
      r_len_q     <= '0;
      r_ovf_q     <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      en_q        <= en_d;
      sod_q       <= sod_d;
      kill_q      <= kill_d;
      char_q      <= char_d;
      r_valid_q   <= r_valid_d;
      r_match_q   <= r_match_d;
      r_len_q     <= r_len_d;
      r_ovf_q     <= r_ovf_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.en       = en_q;
  assign bus.sod      = sod_q;
  assign bus.chr_kill = kill_q;
  assign bus.char_o   = char_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_match  = r_match_q;
  assign bus.r_len    = r_len_q;
  assign bus.r_ovf    = r_ovf_q;

endmodule

// File: tb/tb_nfa_stream_feeder.sv
// Directed bench for nfa_stream_feeder: a default instance driving a small
// engine model and a LEN_W=4 instance for length saturation.
module tb_nfa_stream_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nfa_stream_feeder_if #(.NUM_ENG(8), .LEN_W(16)) m_if ();
  nfa_stream_feeder_if #(.NUM_ENG(8), .LEN_W(4))  n_if ();

  nfa_stream_feeder #(.NUM_ENG(8), .LEN_W(16), .DRAIN_CYC(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  nfa_stream_feeder #(.NUM_ENG(8), .LEN_W(4), .DRAIN_CYC(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (n_if.slave)
  );

  // Behavioural engine_4: sticky match on the substring "c.smx?u=".
  localparam logic [63:0] PAT = "c.smx?u=";
  logic [7:0] eng_st;
  logic [7:0] eng_nxt;
  logic [7:0] eng_prev;
  logic       eng_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_st  <= '0;
      eng_out <= 1'b0;
    end else if (m_if.en) begin
      if (m_if.sod) begin
        eng_st  <= '0;
        eng_out <= 1'b0;
      end else begin
        eng_prev = {eng_st[6:0], 1'b1};
        for (int i = 0; i < 8; i++)
          eng_nxt[i] = !m_if.chr_kill && (m_if.char_o == PAT[63-8*i -: 8]) && eng_prev[i];
        eng_st  <= eng_nxt;
        eng_out <= eng_out | eng_st[7];
      end
    end
  end

  assign m_if.match_i = {3'b000, eng_out, 4'b0000};
  assign n_if.match_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] pkt_q[$];

  task automatic load(input string s);
    pkt_q.delete();
    for (int i = 0; i < s.len(); i++) pkt_q.push_back(s[i]);
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      n_if.s_valid = v; n_if.s_data = d; n_if.s_last = l;
    end else begin
      m_if.s_valid = v; m_if.s_data = d; m_if.s_last = l;
    end
  endtask

  task automatic send(input bit sel);
    int i = 0;
    int b = 0;
    int n = pkt_q.size();
    @(negedge clk);
    while (i < n && b < 500) begin
      drive(sel, 1'b1, pkt_q[i], i == n - 1);
      if (sel ? n_if.s_ready : m_if.s_ready) i++;
      @(negedge clk);
      b++;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
    check("send_bytes", i, n);
  endtask

  task automatic wait_report(input bit sel);
    int b = 0;
    while (!(sel ? n_if.r_valid : m_if.r_valid) && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("report_in_time", b < 100, 1);
  endtask

  task automatic ack(input bit sel);
    if (sel) n_if.r_ready = 1'b1; else m_if.r_ready = 1'b1;
    @(negedge clk);
    if (sel) n_if.r_ready = 1'b0; else m_if.r_ready = 1'b0;
    check("ack_r_valid_low", sel ? n_if.r_valid : m_if.r_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},  m_if.s_ready,  0);
    check({tag, "_en"},       m_if.en,       0);
    check({tag, "_sod"},      m_if.sod,      0);
    check({tag, "_chr_kill"}, m_if.chr_kill, 0);
    check({tag, "_char_o"},   m_if.char_o,   0);
    check({tag, "_r_valid"},  m_if.r_valid,  0);
    check({tag, "_r_match"},  m_if.r_match,  0);
    check({tag, "_r_len"},    m_if.r_len,    0);
    check({tag, "_r_ovf"},    m_if.r_ovf,    0);
  endtask

  // Back-to-back 1-byte packets, cycle 0 is the IDLE cycle that sees s_valid.
  logic [12:1] exp_sod   = 12'b0000_0100_0001;
  logic [12:1] exp_en    = 12'b0011_1100_1111;
  logic [12:1] exp_kill  = 12'b0011_0100_1101;
  logic [12:1] exp_rv    = 12'b0100_0001_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    int b;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    m_if.r_ready = 1'b0;
    n_if.r_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_dut4_r_len", n_if.r_len, 0);
    rst = 1'b1;
    @(negedge clk);

    // Matching URL: engine_4 fires.
    load("/cbn/c.smx?u=");
    send(1'b0);
    wait_report(1'b0);
    check("match_r_match", m_if.r_match, 32'h10);
    check("match_r_len",   m_if.r_len,   13);
    check("match_r_ovf",   m_if.r_ovf,   0);
    ack(1'b0);

    // Near-miss URL of the same length.
    load("/cbn/b.smx\ru=");
    send(1'b0);
    wait_report(1'b0);
    check("miss_r_match", m_if.r_match, 0);
    check("miss_r_len",   m_if.r_len,   13);
    ack(1'b0);

    // Report back-pressure with the next packet already waiting.
    load("ab");
    send(1'b0);
    wait_report(1'b0);
    drive(1'b0, 1'b1, 8'h75, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("hold_r_valid", m_if.r_valid, 1);
      check("hold_r_len",   m_if.r_len,   2);
      check("hold_r_match", m_if.r_match, 0);
      check("hold_r_ovf",   m_if.r_ovf,   0);
      check("hold_s_ready", m_if.s_ready, 0);
    end
    m_if.r_ready = 1'b1;
    @(negedge clk);
    m_if.r_ready = 1'b0;
    check("hold_idle_r_valid", m_if.r_valid, 0);
    check("hold_idle_sod",     m_if.sod,     0);
    check("hold_idle_s_ready", m_if.s_ready, 0);
    @(negedge clk);
    check("hold_clear_sod",     m_if.sod,     1);
    check("hold_clear_s_ready", m_if.s_ready, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("hold_byte_sod",  m_if.sod,      0);
    check("hold_byte_en",   m_if.en,       1);
    check("hold_byte_kill", m_if.chr_kill, 0);
    check("hold_byte_char", m_if.char_o,   32'h75);
    wait_report(1'b0);
    check("hold_next_r_len", m_if.r_len, 1);
    ack(1'b0);

    // Length saturation on the LEN_W=4 instance: exactly full, then over.
    pkt_q.delete();
    for (int n = 0; n < 15; n++) pkt_q.push_back(8'(8'h30 + n));
    send(1'b1);
    wait_report(1'b1);
    check("len15_r_len", n_if.r_len, 15);
    check("len15_r_ovf", n_if.r_ovf, 0);
    ack(1'b1);
    pkt_q.delete();
    for (int n = 0; n < 20; n++) pkt_q.push_back(8'(8'h40 + n));
    send(1'b1);
    wait_report(1'b1);
    check("len20_r_len", n_if.r_len, 15);
    check("len20_r_ovf", n_if.r_ovf, 1);
    ack(1'b1);

    // Back-to-back 1-byte packets with r_ready held high.
    m_if.r_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h41, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("b2b_sod_%0d", n),     m_if.sod,      exp_sod[n]);
      check($sformatf("b2b_en_%0d", n),      m_if.en,       exp_en[n]);
      check($sformatf("b2b_kill_%0d", n),    m_if.chr_kill, exp_kill[n]);
      check($sformatf("b2b_r_valid_%0d", n), m_if.r_valid,  exp_rv[n]);
      if (n == 5 || n == 11) check($sformatf("b2b_r_len_%0d", n), m_if.r_len, 1);
      if (n == 8) drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    m_if.r_ready = 1'b0;

    // Reset while byte 5 of a 10-byte packet is on the bus.
    load("0123456789");
    i = 0;
    b = 0;
    @(negedge clk);
    while (i < 4 && b < 50) begin
      drive(1'b0, 1'b1, pkt_q[i], 1'b0);
      if (m_if.s_ready) i++;
      @(negedge clk);
      b++;
    end
    check("abort_pre_bytes",   i, 4);
    drive(1'b0, 1'b1, pkt_q[4], 1'b0);
    check("abort_pre_en",      m_if.en,      1);
    check("abort_pre_s_ready", m_if.s_ready, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("abort");
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("abort_no_report", m_if.r_valid, 0);
    end
    load("xyz");
    send(1'b0);
    wait_report(1'b0);
    check("after_abort_r_len",   m_if.r_len,   3);
    check("after_abort_r_match", m_if.r_match, 0);
    check("after_abort_r_ovf",   m_if.r_ovf,   0);
    ack(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
